// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter that lets the I-cache and D-cache refill FSMs share one DRAM block port.
// Each granted request is held in registers until the memory acknowledges it; a watchdog flags a stuck memory.
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH     = 128,
    parameter int S_ADDR         = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  i_riscv_arb_clk,
    input  logic                  i_riscv_arb_rst,
    input  logic                  i_riscv_arb_imem_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
    output logic                  o_riscv_arb_imem_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_data_out,
    input  logic                  i_riscv_arb_dmem_rden,
    input  logic                  i_riscv_arb_dmem_wren,
    input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_data_in,
    output logic                  o_riscv_arb_dmem_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_data_out,
    output logic                  o_riscv_arb_mem_rden,
    output logic                  o_riscv_arb_mem_wren,
    output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_data_in,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_data_out,
    input  logic                  i_riscv_arb_mem_ready,
    output logic                  o_riscv_arb_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                  state_reg;
    logic                    last_grant_reg;
    logic                    rden_reg;
    logic                    wren_reg;
    logic [S_ADDR-1:0]       addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    timeout_reg;

    logic                    ireq;
    logic                    dreq;
    logic                    pick_d;
    logic [CNT_W-1:0]        count_next;

    always_comb begin
        ireq       = i_riscv_arb_imem_rden;
        dreq       = i_riscv_arb_dmem_rden | i_riscv_arb_dmem_wren;
        // D wins when it is alone, or on a tie when I was served last.
        pick_d     = dreq & (~ireq | (last_grant_reg == SIDE_I));
        // Saturating watchdog increment.
        count_next = (count_reg == CNT_LIMIT) ? count_reg : count_reg + CNT_W'(1);
    end

    always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
        if (i_riscv_arb_rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= SIDE_I;
            rden_reg       <= 1'b0;
            wren_reg       <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= '0;
            count_reg      <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ireq | dreq) begin
                        count_reg <= '0;
                        if (pick_d) begin
                            state_reg      <= GRANT_D;
                            last_grant_reg <= SIDE_D;
                            addr_reg       <= i_riscv_arb_dmem_addr;
                            data_reg       <= i_riscv_arb_dmem_data_in;
                            wren_reg       <= i_riscv_arb_dmem_wren;
                            rden_reg       <= ~i_riscv_arb_dmem_wren;
                        end else begin
                            state_reg      <= GRANT_I;
                            last_grant_reg <= SIDE_I;
                            addr_reg       <= i_riscv_arb_imem_addr;
                            data_reg       <= '0;
                            wren_reg       <= 1'b0;
                            rden_reg       <= 1'b1;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (i_riscv_arb_mem_ready) begin
                        state_reg <= IDLE;
                        rden_reg  <= 1'b0;
                        wren_reg  <= 1'b0;
                    end else begin
                        // Keep waiting; the error is reported but the transfer is never aborted.
                        count_reg <= count_next;
                        if (count_next == CNT_LIMIT) begin
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rden_reg  <= 1'b0;
                    wren_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_riscv_arb_mem_rden      = rden_reg;
    assign o_riscv_arb_mem_wren      = wren_reg;
    assign o_riscv_arb_mem_addr      = addr_reg;
    assign o_riscv_arb_mem_data_in   = data_reg;
    assign o_riscv_arb_timeout       = timeout_reg;

    // Completion is forwarded only to the side that owns the current grant.
    assign o_riscv_arb_imem_ready    = i_riscv_arb_mem_ready & (state_reg == GRANT_I);
    assign o_riscv_arb_dmem_ready    = i_riscv_arb_mem_ready & (state_reg == GRANT_D);
    assign o_riscv_arb_imem_data_out = i_riscv_arb_mem_data_out;
    assign o_riscv_arb_dmem_data_out = i_riscv_arb_mem_data_out;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed requests push expected grants into a queue,
// and a negedge monitor checks the DRAM-side strobes and requester completions against it.
module tb_riscv_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          imem_rden;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [DW-1:0] imem_data_out;
    logic          dmem_rden;
    logic          dmem_wren;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_data_in;
    logic          dmem_ready;
    logic [DW-1:0] dmem_data_out;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_ready;
    logic          timeout;

    riscv_mem_arbiter #(
        .DATA_WIDTH    (DW),
        .S_ADDR        (AW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_riscv_arb_clk          (clk),
        .i_riscv_arb_rst          (rst),
        .i_riscv_arb_imem_rden    (imem_rden),
        .i_riscv_arb_imem_addr    (imem_addr),
        .o_riscv_arb_imem_ready   (imem_ready),
        .o_riscv_arb_imem_data_out(imem_data_out),
        .i_riscv_arb_dmem_rden    (dmem_rden),
        .i_riscv_arb_dmem_wren    (dmem_wren),
        .i_riscv_arb_dmem_addr    (dmem_addr),
        .i_riscv_arb_dmem_data_in (dmem_data_in),
        .o_riscv_arb_dmem_ready   (dmem_ready),
        .o_riscv_arb_dmem_data_out(dmem_data_out),
        .o_riscv_arb_mem_rden     (mem_rden),
        .o_riscv_arb_mem_wren     (mem_wren),
        .o_riscv_arb_mem_addr     (mem_addr),
        .o_riscv_arb_mem_data_in  (mem_data_in),
        .i_riscv_arb_mem_data_out (mem_data_out),
        .i_riscv_arb_mem_ready    (mem_ready),
        .o_riscv_arb_timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic have_cur;
    logic prev_strobe;
    int   vectors;
    int   miscompares;
    int   gap_w;
    int   lat_tab[6] = '{1, 2, 3, 1, 2, 1};

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] rdv(input int r);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(r);
        return {w, w, w, w};
    endfunction

    // Monitor: a rising strobe pops the next expected grant; a ready closes it.
    initial begin
        have_cur = 1'b0;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_cur = 1'b0;
                prev_strobe = 1'b0;
            end else begin
                if ((mem_rden | mem_wren) && !prev_strobe) begin
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_grant: got addr %0h expected no grant", mem_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if ((mem_rden | mem_wren) && have_cur) begin
                    check("mon_rden", mem_rden, !cur.wr);
                    check("mon_wren", mem_wren, cur.wr);
                    check("mon_addr", mem_addr, cur.addr);
                    if (cur.wr) check("mon_wdata", mem_data_in, cur.wdata);
                end
                if (imem_ready || dmem_ready) begin
                    if (!have_cur) begin
                        vectors++; miscompares++;
                        $display("FAIL stray_ready: got i=%0b d=%0b expected none", imem_ready, dmem_ready);
                    end else begin
                        check("mon_iready", imem_ready, !cur.is_d);
                        check("mon_dready", dmem_ready, cur.is_d);
                        check("mon_rdata", cur.is_d ? dmem_data_out : imem_data_out, cur.rdata);
                        have_cur = 1'b0;
                    end
                end
                prev_strobe = mem_rden | mem_wren;
            end
        end
    end

    task automatic wait_side(input logic d_side);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = d_side ? dmem_ready : imem_ready;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL wait_ready side %0d: got no ready expected ready within 100 cycles", d_side);
        end
    endtask

    task automatic run_i(input int n, input logic [AW-1:0] base);
        for (int k = 0; k < n; k++) begin
            imem_rden = 1'b1;
            imem_addr = base + AW'(k);
            wait_side(1'b0);
            @(posedge clk); #1;
        end
        imem_rden = 1'b0;
    endtask

    task automatic run_d(input int n, input logic [AW-1:0] base, input logic [2:0] wr_mask,
                         input logic [DW-1:0] wbase);
        for (int k = 0; k < n; k++) begin
            dmem_wren    = wr_mask[k];
            dmem_rden    = !wr_mask[k];
            dmem_addr    = base + AW'(k);
            dmem_data_in = wbase + DW'(k);
            wait_side(1'b1);
            @(posedge clk); #1;
        end
        dmem_rden = 1'b0;
        dmem_wren = 1'b0;
    endtask

    // DRAM model: waits for a strobe, answers in its lat-th strobe cycle.
    task automatic dram_serve(input int lat, input logic [DW-1:0] d, output int waited);
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!(mem_rden || mem_wren) && waited < 100);
        check("dram_strobe_seen", mem_rden | mem_wren, 1);
        repeat (lat - 1) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        mem_data_out = d;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_data_out = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "bench did not complete");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        imem_rden = 0; imem_addr = '0;
        dmem_rden = 0; dmem_wren = 0; dmem_addr = '0; dmem_data_in = '0;
        mem_ready = 0; mem_data_out = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rden", mem_rden, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_data_in, 0);
        check("rst_iready", imem_ready, 0);
        check("rst_dready", dmem_ready, 0);
        check("rst_timeout", timeout, 0);

        // 1: single I read, DRAM answers in the 3rd strobe cycle.
        push(0, 0, 10'h005, '0, {16{8'hA5}});
        @(posedge clk); #1; imem_rden = 1; imem_addr = 10'h005;
        @(negedge clk); check("t1_no_strobe_before_T", mem_rden, 0);
        @(posedge clk); #1; check("t1_strobe_c1", mem_rden, 1);
        @(posedge clk); #1; check("t1_strobe_c2", mem_rden, 1);
        @(posedge clk); #1; check("t1_strobe_c3", mem_rden, 1);
        mem_ready = 1; mem_data_out = {16{8'hA5}};
        @(negedge clk);
        check("t1_iready", imem_ready, 1);
        check("t1_dready", dmem_ready, 0);
        @(posedge clk); #1; mem_ready = 0; mem_data_out = '0; imem_rden = 0;
        check("t1_strobe_drop", mem_rden, 0);

        // 2: continuous contention after reset; D first, then strict alternation.
        rst = 1; @(posedge clk); #1; rst = 0;
        push(1, 1, 10'h002, 128'h1234, rdv(0));
        push(0, 0, 10'h001, '0, rdv(1));
        push(1, 0, 10'h003, '0, rdv(2));
        push(0, 0, 10'h002, '0, rdv(3));
        push(1, 1, 10'h004, 128'h1236, rdv(4));
        push(0, 0, 10'h003, '0, rdv(5));
        @(posedge clk); #1;
        fork
            run_i(3, 10'h001);
            run_d(3, 10'h002, 3'b101, 128'h1234);
            begin
                for (int r = 0; r < 6; r++) begin
                    dram_serve(lat_tab[r], rdv(r), gap_w);
                    check("t2_grant_gap", gap_w, 1);
                end
            end
        join

        // 3: D with both rden and wren; requester inputs wander while granted.
        push(1, 1, 10'h3AA, {4{32'hCAFE_F00D}}, 128'h77);
        @(posedge clk); #1;
        dmem_rden = 1; dmem_wren = 1; dmem_addr = 10'h3AA; dmem_data_in = {4{32'hCAFE_F00D}};
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            dmem_addr = 10'h155 + AW'(c);
            dmem_data_in = ~{4{32'hCAFE_F00D}} + DW'(c);
            @(posedge clk); #1;
        end
        check("t3_addr_held", mem_addr, 10'h3AA);
        check("t3_data_held", mem_data_in, {4{32'hCAFE_F00D}});
        check("t3_wren_priority", mem_rden, 0);
        mem_ready = 1; mem_data_out = 128'h77;
        @(negedge clk); check("t3_dready", dmem_ready, 1);
        @(posedge clk); #1; mem_ready = 0; mem_data_out = '0; dmem_rden = 0; dmem_wren = 0;

        // 4: stray ready in IDLE.
        @(posedge clk); #1; mem_ready = 1; mem_data_out = 128'hBAD;
        @(negedge clk);
        check("t4_iready", imem_ready, 0);
        check("t4_dready", dmem_ready, 0);
        @(posedge clk); #1; mem_ready = 0; mem_data_out = '0;
        @(negedge clk);
        check("t4_rden_idle", mem_rden, 0);
        check("t4_wren_idle", mem_wren, 0);

        // 5: watchdog with limit 8; the transfer still completes afterwards.
        push(1, 0, 10'h011, '0, rdv(9));
        @(posedge clk); #1; dmem_rden = 1; dmem_addr = 10'h011;
        @(posedge clk);
        for (int g = 1; g <= 8; g++) begin
            @(negedge clk); check($sformatf("t5_timeout_low_c%0d", g), timeout, 0);
        end
        @(negedge clk); check("t5_timeout_set", timeout, 1);
        repeat (3) @(negedge clk);
        check("t5_still_pending", mem_rden, 1);
        @(posedge clk); #1; mem_ready = 1; mem_data_out = rdv(9);
        @(negedge clk); check("t5_dready", dmem_ready, 1);
        @(posedge clk); #1; mem_ready = 0; mem_data_out = '0; dmem_rden = 0;
        @(negedge clk);
        check("t5_timeout_sticky", timeout, 1);
        check("t5_strobe_drop", mem_rden, 0);

        // 6: asynchronous reset in the middle of a D write.
        push(1, 1, 10'h020, 128'h5555, '0);
        @(posedge clk); #1; dmem_wren = 1; dmem_addr = 10'h020; dmem_data_in = 128'h5555;
        @(posedge clk);
        @(negedge clk); check("t6_wren_granted", mem_wren, 1);
        #2 rst = 1; mem_ready = 1;
        #1;
        check("t6_async_wren", mem_wren, 0);
        check("t6_async_rden", mem_rden, 0);
        check("t6_async_dready", dmem_ready, 0);
        check("t6_async_iready", imem_ready, 0);
        check("t6_async_timeout", timeout, 0);
        mem_ready = 0; dmem_wren = 0;
        @(negedge clk);
        push(0, 0, 10'h00F, '0, rdv(7));
        @(posedge clk); #1; rst = 0; imem_rden = 1; imem_addr = 10'h00F;
        @(negedge clk); check("t6_no_strobe_before_T", mem_rden, 0);
        @(posedge clk); #1; check("t6_strobe_T1", mem_rden, 1);
        mem_ready = 1; mem_data_out = rdv(7);
        @(negedge clk); check("t6_iready", imem_ready, 1);
        @(posedge clk); #1; mem_ready = 0; mem_data_out = '0; imem_rden = 0;
        check("t6_strobe_drop", mem_rden, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("no_open_grant", have_cur, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
